// File: rtl/xm_sequencer_if.sv
// Control bundle between the X-Makina sequencer and its datapath/debug logic.
// Purely signal grouping; no timing of its own.
// Handshake is memRdy_i only; the sequencer stalls in its wait states until it is seen.
interface xm_sequencer_if #(
  parameter int RET_W = 32
);
  // Inputs to the sequencer
  logic             memRdy_i;
  logic [2:0]       instrClass_i;
  logic             branchTaken_i;
  logic             badMem_i;
  logic             dbgHalt_i;
  logic             dbgStep_i;

  // Datapath strobes
  logic             memEn_o;
  logic             memWe_o;
  logic             pcWr_o;
  logic             regWr_o;
  logic             irWr_o;
  logic             flagsWr_o;
  logic             tempWr_o;

  // Datapath selects
  logic             pcSel_o;
  logic [1:0]       adrSel_o;
  logic [1:0]       aluBSel_o;
  logic [2:0]       regWrSel_o;

  // Status
  logic             halted_o;
  logic             fault_o;
  logic [1:0]       faultCode_o;
  logic [RET_W-1:0] retired_o;

  // Sequencer side
  modport master (
    input  memRdy_i, instrClass_i, branchTaken_i, badMem_i, dbgHalt_i, dbgStep_i,
    output memEn_o, memWe_o, pcWr_o, regWr_o, irWr_o, flagsWr_o, tempWr_o,
    output pcSel_o, adrSel_o, aluBSel_o, regWrSel_o,
    output halted_o, fault_o, faultCode_o, retired_o
  );

  // Datapath / debug side
  modport slave (
    output memRdy_i, instrClass_i, branchTaken_i, badMem_i, dbgHalt_i, dbgStep_i,
    input  memEn_o, memWe_o, pcWr_o, regWr_o, irWr_o, flagsWr_o, tempWr_o,
    input  pcSel_o, adrSel_o, aluBSel_o, regWrSel_o,
    input  halted_o, fault_o, faultCode_o, retired_o
  );
endinterface

// File: rtl/xm_sequencer.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the X-Makina datapath.
// Latency: 4 cycles per register instruction, 5+ for load/store (plus memory wait cycles).
// Backpressure: stalls in FETCH_WAIT/MEM_WAIT until memRdy_i; faults after TIMEOUT idle cycles.
module xm_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 32
) (
  input  logic          clk_i,
  input  logic          arst_i,
  xm_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  // State encoding
  localparam logic [2:0] S_FETCH      = 3'd0;
  localparam logic [2:0] S_FETCH_WAIT = 3'd1;
  localparam logic [2:0] S_DECODE     = 3'd2;
  localparam logic [2:0] S_EXEC       = 3'd3;
  localparam logic [2:0] S_MEM_WAIT   = 3'd4;
  localparam logic [2:0] S_HALT       = 3'd5;
  localparam logic [2:0] S_FAULT      = 3'd6;

  // Instruction classes from the decoder
  localparam logic [2:0] C_ALU_REG   = 3'd0;
  localparam logic [2:0] C_ALU_CONST = 3'd1;
  localparam logic [2:0] C_MOVE_IMM  = 3'd2;
  localparam logic [2:0] C_LOAD      = 3'd3;
  localparam logic [2:0] C_STORE     = 3'd4;
  localparam logic [2:0] C_BRANCH    = 3'd5;

  // Fault causes
  localparam logic [1:0] F_INVALID = 2'd1;
  localparam logic [1:0] F_BADMEM  = 2'd2;
  localparam logic [1:0] F_TIMEOUT = 2'd3;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       class_q, class_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic [1:0]       code_q, code_d;
  // step_pend: a single step was granted and its instruction has not retired yet.
  // step_ret:  the stepped instruction retired; the next FETCH goes back to HALT.
  logic             step_pend_q, step_pend_d;
  logic             step_ret_q, step_ret_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             timed_out;
  logic             retire;

  logic             mem_en, mem_we, pc_wr, reg_wr, ir_wr, flags_wr;
  logic             pc_sel;
  logic [1:0]       adr_sel, alub_sel;
  logic [2:0]       reg_wr_sel;

  // Next-state, datapath strobes and selects from current state plus live inputs
  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    code_d      = code_q;
    step_pend_d = step_pend_q;
    step_ret_d  = step_ret_q;
    retired_d   = retired_q;
    retire      = 1'b0;
    cnt_inc     = cnt_q + CNT_W'(1);
    timed_out   = (cnt_inc == CNT_LIMIT);

    mem_en      = 1'b0;
    mem_we      = 1'b0;
    pc_wr       = 1'b0;
    reg_wr      = 1'b0;
    ir_wr       = 1'b0;
    flags_wr    = 1'b0;
    pc_sel      = 1'b0;
    adr_sel     = 2'd0;
    alub_sel    = 2'd0;
    reg_wr_sel  = 3'd0;

    case (state_q)
      S_FETCH: begin
        // While a step is pending the still-asserted halt level must not stop the fetch.
        if ((bus.dbgHalt_i && !step_pend_q) || step_ret_q) begin
          state_d    = S_HALT;
          step_ret_d = 1'b0;
        end else begin
          mem_en  = 1'b1;
          adr_sel = 2'd0;
          if (bus.badMem_i) begin
            state_d = S_FAULT;
            code_d  = F_BADMEM;
          end else begin
            state_d = S_FETCH_WAIT;
          end
        end
      end

      S_FETCH_WAIT: begin
        if (bus.memRdy_i) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          pc_sel  = 1'b0;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
          code_d  = F_TIMEOUT;
        end
      end

      S_DECODE: begin
        class_d = bus.instrClass_i;
        if (bus.instrClass_i[2:1] == 2'b11) begin
          state_d = S_FAULT;
          code_d  = F_INVALID;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (class_q)
          C_ALU_REG, C_ALU_CONST: begin
            reg_wr     = 1'b1;
            flags_wr   = 1'b1;
            reg_wr_sel = 3'd0;
            alub_sel   = (class_q == C_ALU_CONST) ? 2'd1 : 2'd0;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          C_MOVE_IMM: begin
            reg_wr     = 1'b1;
            reg_wr_sel = 3'd3;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          C_BRANCH: begin
            pc_wr   = bus.branchTaken_i;
            pc_sel  = bus.branchTaken_i;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: begin
            adr_sel  = 2'd2;
            alub_sel = 2'd2;
            // A bad address never reaches the memory bus.
            if (bus.badMem_i) begin
              state_d = S_FAULT;
              code_d  = F_BADMEM;
            end else begin
              mem_en  = 1'b1;
              mem_we  = (class_q == C_STORE);
              state_d = S_MEM_WAIT;
            end
          end
          default: begin
            // Invalid classes are trapped in DECODE; treat a stray one the same way.
            state_d = S_FAULT;
            code_d  = F_INVALID;
          end
        endcase
      end

      S_MEM_WAIT: begin
        if (bus.memRdy_i) begin
          if (class_q == C_LOAD) begin
            reg_wr     = 1'b1;
            reg_wr_sel = 3'd2;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_FAULT;
          code_d  = F_TIMEOUT;
        end
      end

      S_HALT: begin
        if (bus.dbgStep_i) begin
          step_pend_d = 1'b1;
          state_d     = S_FETCH;
        end else if (!bus.dbgHalt_i) begin
          state_d = S_FETCH;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) begin
      retired_d = retired_q + RET_W'(1);
      if (step_pend_q) begin
        step_pend_d = 1'b0;
        step_ret_d  = 1'b1;
      end
    end

    // The wait counter only runs while parked in a wait state; any move clears it.
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == S_FETCH_WAIT) || (state_q == S_MEM_WAIT))) begin
      cnt_d = cnt_inc;
    end
  end

  // Sequencer state registers, cleared immediately by reset
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      class_q     <= 3'd0;
      retired_q   <= '0;
      code_q      <= 2'd0;
      step_pend_q <= 1'b0;
      step_ret_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      class_q     <= class_d;
      retired_q   <= retired_d;
      code_q      <= code_d;
      step_pend_q <= step_pend_d;
      step_ret_q  <= step_ret_d;
    end
  end

  // Strobes are gated by reset so an in-flight access is dropped at once.
  assign bus.memEn_o     = arst_i & mem_en;
  assign bus.memWe_o     = arst_i & mem_we;
  assign bus.pcWr_o      = arst_i & pc_wr;
  assign bus.regWr_o     = arst_i & reg_wr;
  assign bus.irWr_o      = arst_i & ir_wr;
  assign bus.flagsWr_o   = arst_i & flags_wr;
  assign bus.tempWr_o    = 1'b0;
  assign bus.pcSel_o     = arst_i & pc_sel;
  assign bus.adrSel_o    = arst_i ? adr_sel : 2'd0;
  assign bus.aluBSel_o   = arst_i ? alub_sel : 2'd0;
  assign bus.regWrSel_o  = arst_i ? reg_wr_sel : 3'd0;

  assign bus.halted_o    = (state_q == S_HALT);
  assign bus.fault_o     = (state_q == S_FAULT);
  assign bus.faultCode_o = code_q;
  assign bus.retired_o   = retired_q;

endmodule
